// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the i2c transaction arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    XFER,
    GAP
  } arbState_t;

  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_GAP_CYCLES = 64;
  localparam int unsigned ADDR_W         = 7;
  localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/i2c_txn_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         pickOh,
  output logic [$clog2(N_REQ)-1:0] pickIdx,
  output logic                     pickAny
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    pickOh  = '0;
    pickIdx = '0;
    pickAny = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!pickAny && req[cand]) begin
        pickAny       = 1'b1;
        pickIdx       = cand;
        pickOh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c master between N_REQ clients: round-robin grant, byte routing,
// byte counting, done/err pulses and a guard gap before the next grant.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [ADDR_W*N_REQ-1:0]   reqAddr,
  input  logic [N_REQ-1:0]          reqRdWr,
  input  logic [BYTE_W*N_REQ-1:0]   reqLen,
  input  logic [BYTE_W*N_REQ-1:0]   wrData,
  input  logic [N_REQ-1:0]          wrValid,
  output logic [N_REQ-1:0]          wrReady,
  output logic [BYTE_W-1:0]         rdData,
  output logic [N_REQ-1:0]          rdValid,
  input  logic [N_REQ-1:0]          rdReady,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [ADDR_W-1:0]         addr,
  output logic                      rdWr,
  output logic [BYTE_W-1:0]         inData,
  output logic                      inValid,
  input  logic                      inReady,
  input  logic [BYTE_W-1:0]         outData,
  input  logic                      outValid,
  output logic                      outReady
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arbState_t state, stateNext;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [BYTE_W-1:0] len;
  logic [BYTE_W-1:0] count;
  logic [GAP_W-1:0]  gapCnt;

  logic [ADDR_W-1:0] addrArr   [N_REQ];
  logic [BYTE_W-1:0] lenArr    [N_REQ];
  logic [BYTE_W-1:0] wrDataArr [N_REQ];

  logic [N_REQ-1:0]  pickOh;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickAny;
  logic [ADDR_W-1:0] selAddr;
  logic [BYTE_W-1:0] selLen;
  logic              selRdWr;
  logic              selZero;

  logic hs;
  logic lastByte;

  // Split the flat per-requester buses into indexable arrays.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      addrArr[i]   = reqAddr[ADDR_W*i +: ADDR_W];
      lenArr[i]    = reqLen[BYTE_W*i +: BYTE_W];
      wrDataArr[i] = wrData[BYTE_W*i +: BYTE_W];
    end
  end

  rr_picker #(
    .N_REQ(N_REQ)
  ) uPicker (
    .req    (req),
    .ptr    (ptr),
    .pickOh (pickOh),
    .pickIdx(pickIdx),
    .pickAny(pickAny)
  );

  // Winner's transaction descriptor and the per-byte handshake of the owner.
  always_comb begin
    selAddr  = addrArr[pickIdx];
    selLen   = lenArr[pickIdx];
    selRdWr  = reqRdWr[pickIdx];
    selZero  = (selLen == '0);
    hs       = 1'b0;
    if (state == XFER) begin
      hs = rdWr ? (outValid && rdReady[owner]) : (wrValid[owner] && inReady);
    end
    lastByte = (count == len - 8'd1);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (|req) stateNext = ARB;
      ARB: begin
        if (!pickAny)     stateNext = IDLE;
        else if (selZero) stateNext = GAP;
        else              stateNext = XFER;
      end
      XFER: if (hs && lastByte) stateNext = GAP;
      GAP:  if (gapCnt == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Transaction latches, rr pointer, byte and gap counters, registered grant/done/err.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr    <= '0;
      owner  <= '0;
      addr   <= '0;
      rdWr   <= 1'b0;
      len    <= '0;
      count  <= '0;
      gapCnt <= '0;
      grant  <= '0;
      done   <= '0;
      err    <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      unique case (state)
        ARB: begin
          if (pickAny) begin
            owner <= pickIdx;
            addr  <= selAddr;
            rdWr  <= selRdWr;
            len   <= selLen;
            count <= '0;
            ptr   <= (pickIdx == LAST_IDX) ? '0 : pickIdx + 1'b1;
            if (selZero) begin
              done   <= pickOh;
              err    <= pickOh;
              gapCnt <= GAP_LOAD;
            end else begin
              grant <= pickOh;
            end
          end
        end
        XFER: begin
          if (hs) begin
            count <= count + 8'd1;
            if (lastByte) begin
              done   <= grant;
              grant  <= '0;
              gapCnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gapCnt != '0) gapCnt <= gapCnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stream routing to/from the owner. Gated by reset so the master sees
  // valid/ready fall in the same cycle reset is raised.
  always_comb begin
    inData   = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    wrReady  = '0;
    rdValid  = '0;
    rdData   = outData;
    if (state == XFER && !reset) begin
      if (!rdWr) begin
        inData         = wrDataArr[owner];
        inValid        = wrValid[owner];
        wrReady[owner] = inReady;
      end else begin
        outReady       = rdReady[owner];
        rdValid[owner] = outValid;
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter against a transaction-level reference model.
module tb_i2c_txn_arbiter;

  localparam int N = 4;
  localparam int G = 8;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0]   req, reqRdWr, wrValid, wrReady, rdValid, rdReady, grant, done, err;
  logic [7*N-1:0] reqAddr;
  logic [8*N-1:0] reqLen, wrData;
  logic [7:0]     rdData, inData, outData;
  logic [6:0]     addr;
  logic           rdWr, inValid, inReady, outValid, outReady;

  always #5 clock = ~clock;

  i2c_txn_arbiter #(
    .N_REQ     (N),
    .GAP_CYCLES(G)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .reqAddr (reqAddr),
    .reqRdWr (reqRdWr),
    .reqLen  (reqLen),
    .wrData  (wrData),
    .wrValid (wrValid),
    .wrReady (wrReady),
    .rdData  (rdData),
    .rdValid (rdValid),
    .rdReady (rdReady),
    .grant   (grant),
    .done    (done),
    .err     (err),
    .addr    (addr),
    .rdWr    (rdWr),
    .inData  (inData),
    .inValid (inValid),
    .inReady (inReady),
    .outData (outData),
    .outValid(outValid),
    .outReady(outReady)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Client-side transaction state.
  bit         pend [N];
  logic [6:0] addrM [N];
  bit         dirM [N];
  int         lenM [N];
  int         sent [N];
  logic [7:0] cliBytes [N][256];

  // Reference model state.
  int         ptrM, owner, cnt, doneDue, sinceEnd, txnCount, zlCount, stallLeft;
  logic [N-1:0] lastReq;
  int         grantLog[$];
  bit         holdMode, randomNew, fastMaster, exactGap;

  function automatic int rrPick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit modelIdle();
    bit any = 1'b0;
    for (int i = 0; i < N; i++) any |= pend[i];
    return !any && owner < 0 && doneDue < 0;
  endfunction

  task automatic newTxn(input int i, input logic [6:0] a, input bit d, input int l);
    addrM[i] = a;
    dirM[i]  = d;
    lenM[i]  = l;
    sent[i]  = 0;
    for (int k = 0; k < 256; k++) cliBytes[i][k] = 8'($urandom);
    pend[i]  = 1'b1;
  endtask

  task automatic releaseClient(input int i);
    if (holdMode) newTxn(i, 7'($urandom), 1'($urandom_range(0, 1)), 1);
    else pend[i] = 1'b0;
  endtask

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      if (randomNew && !pend[i] && $urandom_range(0, 11) == 0)
        newTxn(i, 7'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
      req[i]            = pend[i];
      reqAddr[7*i +: 7] = addrM[i];
      reqRdWr[i]        = dirM[i];
      reqLen[8*i +: 8]  = 8'(lenM[i]);
      wrValid[i]        = pend[i] && !dirM[i] && (sent[i] < lenM[i]) &&
                          (fastMaster || $urandom_range(0, 3) != 0);
      wrData[8*i +: 8]  = cliBytes[i][sent[i] % 256];
      rdReady[i]        = fastMaster || $urandom_range(0, 2) != 0;
    end
    if (stallLeft > 0) begin
      inReady = 1'b0;
      stallLeft--;
    end else begin
      inReady = fastMaster || $urandom_range(0, 3) != 0;
    end
    outValid = fastMaster || $urandom_range(0, 2) != 0;
    outData  = 8'($urandom);
  endtask

  task automatic checkCycle();
    int w;
    bit hs;
    hs = 1'b0;
    if (doneDue >= 0) begin
      checkEq("doneOwner", done, 32'(1 << doneDue));
      checkEq("doneNoErr", err, 0);
      checkEq("grantDropAtDone", grant, 0);
      txnCount++;
      releaseClient(doneDue);
      doneDue  = -1;
      sinceEnd = 1;
    end else if (done != 0) begin
      w = rrPick(lastReq, ptrM);
      checkEq("zlDone", done, (w < 0) ? 0 : 32'(1 << w));
      checkEq("zlErr", err, done);
      checkEq("zlGrant", grant, 0);
      if (w >= 0) begin
        checkEq("zlLen", lenM[w], 0);
        grantLog.push_back(w);
        ptrM = (w + 1) % N;
        zlCount++;
        releaseClient(w);
      end
      sinceEnd = 1;
    end else begin
      checkEq("errQuiet", err, 0);
      if (sinceEnd > 0 && grant == 0) sinceEnd++;
    end

    if (owner < 0 && grant != 0) begin
      w = rrPick(lastReq, ptrM);
      checkEq("grantWinner", grant, (w < 0) ? 0 : 32'(1 << w));
      if (w >= 0) begin
        checkEq("grantAddr", addr, addrM[w]);
        checkEq("grantRdWr", rdWr, dirM[w]);
        checkEq("grantLenNz", lenM[w] != 0, 1);
        if (sinceEnd > 0) begin
          checkEq("gapMin", sinceEnd >= G + 2, 1);
          if (exactGap) checkEq("gapExact", sinceEnd, G + 2);
        end
        owner = w;
        cnt   = 0;
        ptrM  = (w + 1) % N;
        grantLog.push_back(w);
      end
      sinceEnd = 0;
    end

    if (owner >= 0) begin
      checkEq("grantHold", grant, 32'(1 << owner));
      checkEq("addrHold", addr, addrM[owner]);
      checkEq("rdWrHold", rdWr, dirM[owner]);
      if (!dirM[owner]) begin
        checkEq("inValid", inValid, wrValid[owner]);
        if (wrValid[owner]) checkEq("inData", inData, cliBytes[owner][cnt]);
        checkEq("wrReady", wrReady, inReady ? 32'(1 << owner) : 0);
        checkEq("outReadyOnWrite", outReady, 0);
        checkEq("rdValidOnWrite", rdValid, 0);
        hs = wrValid[owner] && inReady;
      end else begin
        checkEq("outReady", outReady, rdReady[owner]);
        checkEq("rdValid", rdValid, outValid ? 32'(1 << owner) : 0);
        checkEq("rdData", rdData, outData);
        checkEq("inValidOnRead", inValid, 0);
        checkEq("wrReadyOnRead", wrReady, 0);
        hs = outValid && rdReady[owner];
      end
      if (hs) begin
        cnt++;
        if (cnt == lenM[owner]) begin
          doneDue = owner;
          owner   = -1;
        end
      end
    end else begin
      checkEq("idleStreams", {inValid, outReady, |wrReady, |rdValid}, 0);
    end

    for (int i = 0; i < N; i++) if (wrValid[i] && wrReady[i]) sent[i]++;
    lastReq = req;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    driveInputs();
    @(negedge clock);
    checkCycle();
  endtask

  task automatic doReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkEq("rstInValid", inValid, 0);
    checkEq("rstOutReady", outReady, 0);
    checkEq("rstWrReady", wrReady, 0);
    checkEq("rstRdValid", rdValid, 0);
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      sent[i] = 0;
    end
    owner = -1; doneDue = -1; cnt = 0; ptrM = 0; sinceEnd = 0; stallLeft = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    driveInputs();
    @(negedge clock);
    checkEq("rstGrant", grant, 0);
    checkEq("rstDone", done, 0);
    checkEq("rstErr", err, 0);
    checkEq("rstAddr", addr, 0);
    checkEq("rstRdWr", rdWr, 0);
    checkEq("rstStreams", {inValid, outReady, |wrReady, |rdValid}, 0);
    lastReq = req;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int k = 0;
    while (k < budget && !modelIdle()) begin
      step();
      k++;
    end
    checkEq({tag, "Idle"}, modelIdle(), 1);
  endtask

  task automatic waitBytes(input int who, input int n, input string tag);
    int k = 0;
    while (!(owner == who && cnt >= n) && k < 200) begin
      step();
      k++;
    end
    checkEq(tag, owner == who && cnt >= n, 1);
  endtask

  int t0;

  initial begin
    reset = 1'b1;
    req = '0; reqRdWr = '0; reqAddr = '0; reqLen = '0; wrData = '0; wrValid = '0; rdReady = '0;
    inReady = 1'b0; outValid = 1'b0; outData = '0;
    holdMode = 0; randomNew = 0; fastMaster = 0; exactGap = 0;
    txnCount = 0; zlCount = 0; owner = -1; doneDue = -1; lastReq = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; addrM[i] = '0; dirM[i] = 0; lenM[i] = 0; sent[i] = 0;
    end
    doReset();

    // Single write of A5 5A FF to 0x50.
    newTxn(0, 7'h50, 1'b0, 3);
    cliBytes[0][0] = 8'hA5; cliBytes[0][1] = 8'h5A; cliBytes[0][2] = 8'hFF;
    t0 = txnCount;
    waitIdle(300, "t1");
    checkEq("t1Txns", txnCount - t0, 1);

    // Two-byte read with random client stalls.
    t0 = txnCount;
    newTxn(2, 7'h2A, 1'b1, 2);
    waitIdle(300, "t2");
    checkEq("t2Txns", txnCount - t0, 1);

    // Contention: all four held, one byte each.
    doReset();
    holdMode = 1; exactGap = 1;
    grantLog.delete();
    for (int i = 0; i < N; i++) newTxn(i, 7'($urandom), 1'($urandom_range(0, 1)), 1);
    for (int k = 0; k < 600 && grantLog.size() < 5; k++) step();
    checkEq("t3Grants", grantLog.size() >= 5, 1);
    holdMode = 0; exactGap = 0;
    waitIdle(600, "t3");
    for (int k = 0; k < 5 && k < grantLog.size(); k++)
      checkEq($sformatf("rrOrder%0d", k), grantLog[k], k % N);

    // Zero-length request.
    t0 = zlCount;
    newTxn(1, 7'h11, 1'b0, 0);
    waitIdle(300, "t4");
    checkEq("t4ZeroLen", zlCount - t0, 1);

    // Reset after the first of four bytes; pointer must restart at 0.
    doReset();
    fastMaster = 1;
    newTxn(2, 7'h33, 1'b0, 4);
    waitBytes(2, 1, "t5Started");
    doReset();
    fastMaster = 0;
    grantLog.delete();
    newTxn(3, 7'h03, 1'b0, 1);
    newTxn(0, 7'h00, 1'b1, 1);
    waitIdle(400, "t5");
    checkEq("t5Logged", grantLog.size(), 2);
    if (grantLog.size() > 0) checkEq("t5FirstGrant", grantLog[0], 0);

    // Backpressure: master stalls 20 cycles mid-write.
    fastMaster = 1;
    t0 = txnCount;
    newTxn(1, 7'h44, 1'b0, 6);
    waitBytes(1, 2, "t6Started");
    stallLeft = 20;
    waitIdle(300, "t6");
    checkEq("t6Txns", txnCount - t0, 1);
    checkEq("t6Stall", stallLeft, 0);

    // Random traffic from all clients.
    fastMaster = 0; randomNew = 1;
    t0 = txnCount + zlCount;
    repeat (3000) step();
    randomNew = 0;
    waitIdle(3000, "rand");
    checkEq("randProgress", (txnCount + zlCount - t0) > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
